mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
//   Multicycle MIPS main control FSM. Sequences instruction execution, issues register/memory/PC
//   strobes and drives the 3-bit aluop consumed by the downstream ALU decoder.
//   Sits in the controller beside the ALU decoder; replaces the single-cycle main decoder in the multicycle datapath.
// PARAMETERS
//   none (encodings live in the shared package)
// PORTS
//   clk        in   1  rising-edge clock (single clock domain)
//   rst_n      in   1  asynchronous, active-low reset
//   op         in   6  opcode field of instruction register
//   zero       in   1  ALU zero flag
//   mem_ready  in   1  memory handshake; access completes in a cycle where it is 1
//   pcen       out  1  PC register enable
//   irwrite    out  1  instruction register write
//   regwrite   out  1  register file write
//   memwrite   out  1  data memory write
//   iord       out  1  address mux: 0 = PC, 1 = ALUOut
//   memtoreg   out  1  writeback mux: 1 = memory data
//   regdst     out  1  dest reg: 1 = rd, 0 = rt
//   alusrca    out  1  srcA: 0 = PC, 1 = A
//   alusrcb    out  2  srcB: 00 = B, 01 = 4, 10 = ext imm, 11 = ext imm << 2
//   ext_zero   out  1  imm extension: 1 = zero-extend (andi/ori), 0 = sign
//   pcsrc      out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
//   aluop      out  3  000 add, 001 sub, 100 and, 101 or, 110 slt, 010 R-type (use funct)
//   illegal_op out  1  1 during DECODE when op is unsupported
//   state      out  4  current state (debug)
// BEHAVIOUR
//   - States (4-bit): FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 RTYPEEX=6 RTYPEWB=7
//     BEQEX=8 IMMEX=9 IMMWB=10 JEX=11 BNEEX=12.
//   - Outputs:
//     - All outputs are combinational from state, op, zero and mem_ready.
//     - Any output not listed for a state is 0.
//   - FETCH:
//     - Drives iord=0, alusrca=0, alusrcb=01, aluop=000, pcsrc=00.
//     - irwrite and pcwrite are 1 only when mem_ready=1.
//     - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
//   - DECODE:
//     - Drives alusrca=0, alusrcb=11, aluop=000 (branch target into ALUOut).
//     - Next state by op: lw 100011 / sw 101011 -> MEMADR; 000000 -> RTYPEEX; beq 000100 -> BEQEX;
//       addi 001000, andi 001100, ori 001101, slti 001010 -> IMMEX; j 000010 -> JEX.
//     - Any other op -> FETCH with illegal_op=1.
//   - MEMADR: alusrca=1, alusrcb=10, aluop=000. lw -> MEMRD; sw -> MEMWR.
//   - MEMRD: iord=1; holds while mem_ready=0, then -> MEMWB.
//   - MEMWB: regdst=0, memtoreg=1, regwrite=1; -> FETCH.
//   - MEMWR: iord=1, memwrite=1 on every cycle in the state; holds while mem_ready=0, then -> FETCH.
//   - RTYPEEX: alusrca=1, alusrcb=00, aluop=010; -> RTYPEWB.
//   - RTYPEWB: regdst=1, memtoreg=0, regwrite=1; -> FETCH.
//   - BEQEX: alusrca=1, alusrcb=00, aluop=001, pcsrc=01, branch=1; -> FETCH.
//   - IMMEX: alusrca=1, alusrcb=10.
//     - aluop: addi 000, andi 100, ori 101, slti 110.
//     - ext_zero=1 for andi/ori.
//     - -> IMMWB.
//   - IMMWB: regdst=0, memtoreg=0, regwrite=1; -> FETCH.
//   - JEX: pcsrc=10, pcwrite=1; -> FETCH.
//   - pcen = pcwrite | (branch & zero) | (branch_ne & ~zero).
//     branch and branch_ne are internal signals.
//   - Latency (cycles, mem_ready=1): lw 5, sw 4, R-type 4, imm 4, j 3, beq 3.
//     Each mem_ready=0 cycle adds one cycle.
//   - Reset: rst_n=0 forces state=FETCH immediately, asynchronously, including mid-instruction.
//     With mem_ready=0, all strobes are 0, alusrcb=01, aluop=000, and the other outputs are 0.
//   - Unreachable state codes (13-15) -> FETCH next cycle; all strobes 0 while in them.
// CONFIGURATION
//   MC_CONTROLLER_BNE_EN:
//     - Defined: op 000101 (bne) goes DECODE -> BNEEX.
//       BNEEX drives as BEQEX but asserts branch_ne instead of branch, so pcen = ~zero.
//     - Undefined: op 000101 is illegal (illegal_op=1, -> FETCH); state 12 is treated as unreachable.
// STRUCTURE
//   - Package mc_pkg: state localparams, opcode localparams, aluop code localparams
//     (shared with the ALU decoder).
//   - Single module, no sub-modules: next-state logic, state register and output decode blocks.
// TESTING
//   1. add (op 000000), mem_ready=1 -> states 0,1,6,7,0; regwrite=1, regdst=1 only in state 7;
//      aluop=010 in state 6.
//   2. lw with mem_ready=0 for 2 cycles in MEMRD -> state stays at 3 for 3 cycles;
//      memtoreg=1, regwrite=1 one cycle in state 4; total 7 cycles.
//   3. beq with zero=1 -> pcen=1 in BEQEX, pcsrc=01; with zero=0 -> pcen=0.
//   4. ori (001101) -> IMMEX aluop=101, ext_zero=1; slti -> aluop=110, ext_zero=0.
//   5. op 111111 -> illegal_op=1 in DECODE, next state 0; with MC_CONTROLLER_BNE_EN, bne zero=0 -> pcen=1.
//   6. rst_n pulled low in MEMWR mid-cycle -> state=0 and memwrite=0 before the next clk edge.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: state, opcode and aluop encodings shared by the multicycle controller and ALU decoder
package mc_pkg;
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_IMMEX   = 4'd9;
  localparam logic [3:0] S_IMMWB   = 4'd10;
  localparam logic [3:0] S_JEX     = 4'd11;
  localparam logic [3:0] S_BNEEX   = 4'd12;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_SLT   = 3'b110;
endpackage

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS main control FSM; define MC_CONTROLLER_BNE_EN to add bne (BNEEX)
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       ext_zero,
  output logic [1:0] pcsrc,
  output logic [2:0] aluop,
  output logic       illegal_op,
  output logic [3:0] state
);
  logic [3:0] state_q, state_d, dec_next;
  logic       pcwrite, branch, branch_ne;
  always_comb begin
    dec_next = S_FETCH;
    case (op)
      OP_LW, OP_SW:                     dec_next = S_MEMADR;
      OP_RTYPE:                         dec_next = S_RTYPEEX;
      OP_BEQ:                           dec_next = S_BEQEX;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: dec_next = S_IMMEX;
      OP_J:                             dec_next = S_JEX;
`ifdef MC_CONTROLLER_BNE_EN
      OP_BNE:                           dec_next = S_BNEEX;
`endif
      default:                          dec_next = S_FETCH;
    endcase
  end
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:  state_d = dec_next;
      S_MEMADR:  state_d = op == OP_LW ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_IMMEX:   state_d = S_IMMWB;
      default:   state_d = S_FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  always_comb begin
    pcwrite    = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    ext_zero   = 1'b0;
    pcsrc      = 2'b00;
    aluop      = ALU_ADD;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      S_DECODE: begin
        alusrcb    = 2'b11;
        illegal_op = dec_next == S_FETCH;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALU_RTYPE;
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALU_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
`ifdef MC_CONTROLLER_BNE_EN
      S_BNEEX: begin
        alusrca   = 1'b1;
        aluop     = ALU_SUB;
        pcsrc     = 2'b01;
        branch_ne = 1'b1;
      end
`endif
      S_IMMEX: begin
        alusrca  = 1'b1;
        alusrcb  = 2'b10;
        aluop    = op == OP_ANDI ? ALU_AND : op == OP_ORI ? ALU_OR : op == OP_SLTI ? ALU_SLT : ALU_ADD;
        ext_zero = op == OP_ANDI || op == OP_ORI;
      end
      S_IMMWB: regwrite = 1'b1;
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end
  assign pcen  = pcwrite | (branch & zero) | (branch_ne & ~zero);
  assign state = state_q;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: table-driven directed check of the multicycle control FSM
module tb_mc_controller;
  logic       clk, rst_n, zero, mem_ready;
  logic [5:0] op;
  logic       pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca, ext_zero, illegal_op;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] aluop;
  logic [3:0] state;
  logic [17:0] act_out;
  int errors = 0;
  int checks = 0;
  mc_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite), .memwrite(memwrite),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .ext_zero(ext_zero), .pcsrc(pcsrc), .aluop(aluop),
    .illegal_op(illegal_op), .state(state)
  );
  assign act_out = {pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca,
                    alusrcb, ext_zero, pcsrc, aluop, illegal_op};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // {pcen,irw,rw,mw,iord}_{m2r,rd,asa}_asb_ez_pcsrc_aluop_ill
  localparam logic [17:0] O_F1    = 18'b11000_000_01_0_00_000_0;
  localparam logic [17:0] O_F0    = 18'b00000_000_01_0_00_000_0;
  localparam logic [17:0] O_DEC   = 18'b00000_000_11_0_00_000_0;
  localparam logic [17:0] O_DECI  = 18'b00000_000_11_0_00_000_1;
  localparam logic [17:0] O_MADR  = 18'b00000_001_10_0_00_000_0;
  localparam logic [17:0] O_MRD   = 18'b00001_000_00_0_00_000_0;
  localparam logic [17:0] O_MWB   = 18'b00100_100_00_0_00_000_0;
  localparam logic [17:0] O_MWR   = 18'b00011_000_00_0_00_000_0;
  localparam logic [17:0] O_REX   = 18'b00000_001_00_0_00_010_0;
  localparam logic [17:0] O_RWB   = 18'b00100_010_00_0_00_000_0;
  localparam logic [17:0] O_BR_T  = 18'b10000_001_00_0_01_001_0;
  localparam logic [17:0] O_BR_N  = 18'b00000_001_00_0_01_001_0;
  localparam logic [17:0] O_ADDI  = 18'b00000_001_10_0_00_000_0;
  localparam logic [17:0] O_ANDI  = 18'b00000_001_10_1_00_100_0;
  localparam logic [17:0] O_ORI   = 18'b00000_001_10_1_00_101_0;
  localparam logic [17:0] O_SLTI  = 18'b00000_001_10_0_00_110_0;
  localparam logic [17:0] O_IWB   = 18'b00100_000_00_0_00_000_0;
  localparam logic [17:0] O_JEX   = 18'b10000_000_00_0_10_000_0;
  typedef struct {
    logic [5:0]  op;
    logic        zero;
    logic        rdy;
    logic [3:0]  st;
    logic [17:0] out;
    string       name;
  } vec_t;
  vec_t vecs[$];
  task automatic add(input logic [5:0] o, input logic z, input logic r, input logic [3:0] s,
                     input logic [17:0] e, input string n);
    vec_t v;
    v.op = o; v.zero = z; v.rdy = r; v.st = s; v.out = e; v.name = n;
    vecs.push_back(v);
  endtask
  task automatic chk(input string name, input logic [21:0] act, input logic [21:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got state=%0d out=%b, expected state=%0d out=%b",
               name, act[21:18], act[17:0], exp[21:18], exp[17:0]);
    end
  endtask
  initial begin
    add(6'b000000, 0, 1, 0,  O_F1,  "add_fetch");
    add(6'b000000, 0, 1, 1,  O_DEC, "add_decode");
    add(6'b000000, 0, 1, 6,  O_REX, "add_rtypeex");
    add(6'b000000, 0, 1, 7,  O_RWB, "add_rtypewb");
    add(6'b100011, 0, 1, 0,  O_F1,  "lw_fetch");
    add(6'b100011, 0, 1, 1,  O_DEC, "lw_decode");
    add(6'b100011, 0, 1, 2,  O_MADR,"lw_memadr");
    add(6'b100011, 0, 0, 3,  O_MRD, "lw_memrd_w1");
    add(6'b100011, 0, 0, 3,  O_MRD, "lw_memrd_w2");
    add(6'b100011, 0, 1, 3,  O_MRD, "lw_memrd_go");
    add(6'b100011, 0, 1, 4,  O_MWB, "lw_memwb");
    add(6'b101011, 0, 0, 0,  O_F0,  "sw_fetch_wait");
    add(6'b101011, 0, 1, 0,  O_F1,  "sw_fetch");
    add(6'b101011, 0, 1, 1,  O_DEC, "sw_decode");
    add(6'b101011, 0, 1, 2,  O_MADR,"sw_memadr");
    add(6'b101011, 0, 0, 5,  O_MWR, "sw_memwr_wait");
    add(6'b101011, 0, 1, 5,  O_MWR, "sw_memwr_go");
    add(6'b000100, 1, 1, 0,  O_F1,  "beq1_fetch");
    add(6'b000100, 1, 1, 1,  O_DEC, "beq1_decode");
    add(6'b000100, 1, 1, 8,  O_BR_T,"beq_taken");
    add(6'b000100, 0, 1, 0,  O_F1,  "beq0_fetch");
    add(6'b000100, 0, 1, 1,  O_DEC, "beq0_decode");
    add(6'b000100, 0, 1, 8,  O_BR_N,"beq_not_taken");
    add(6'b001101, 0, 1, 0,  O_F1,  "ori_fetch");
    add(6'b001101, 0, 1, 1,  O_DEC, "ori_decode");
    add(6'b001101, 0, 1, 9,  O_ORI, "ori_immex");
    add(6'b001101, 0, 1, 10, O_IWB, "ori_immwb");
    add(6'b001010, 0, 1, 0,  O_F1,  "slti_fetch");
    add(6'b001010, 0, 1, 1,  O_DEC, "slti_decode");
    add(6'b001010, 0, 1, 9,  O_SLTI,"slti_immex");
    add(6'b001010, 0, 1, 10, O_IWB, "slti_immwb");
    add(6'b001000, 0, 1, 0,  O_F1,  "addi_fetch");
    add(6'b001000, 0, 1, 1,  O_DEC, "addi_decode");
    add(6'b001000, 0, 1, 9,  O_ADDI,"addi_immex");
    add(6'b001000, 0, 1, 10, O_IWB, "addi_immwb");
    add(6'b001100, 0, 1, 0,  O_F1,  "andi_fetch");
    add(6'b001100, 0, 1, 1,  O_DEC, "andi_decode");
    add(6'b001100, 0, 1, 9,  O_ANDI,"andi_immex");
    add(6'b001100, 0, 1, 10, O_IWB, "andi_immwb");
    add(6'b000010, 0, 1, 0,  O_F1,  "j_fetch");
    add(6'b000010, 0, 1, 1,  O_DEC, "j_decode");
    add(6'b000010, 0, 1, 11, O_JEX, "j_jex");
    add(6'b111111, 0, 1, 0,  O_F1,  "ill_fetch");
    add(6'b111111, 0, 1, 1,  O_DECI,"ill_decode");
    add(6'b000101, 0, 1, 0,  O_F1,  "bne_fetch");
`ifdef MC_CONTROLLER_BNE_EN
    add(6'b000101, 0, 1, 1,  O_DEC, "bne_decode");
    add(6'b000101, 0, 1, 12, O_BR_T,"bne_taken");
`else
    add(6'b000101, 0, 1, 1,  O_DECI,"bne_illegal");
`endif
    rst_n = 1'b0; op = 6'b0; zero = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk("reset_state", {state, act_out}, {4'd0, O_F0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      op = vecs[i].op; zero = vecs[i].zero; mem_ready = vecs[i].rdy;
      @(negedge clk);
      chk(vecs[i].name, {state, act_out}, {vecs[i].st, vecs[i].out});
      @(posedge clk); #1;
    end
    op = 6'b101011; zero = 1'b0; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 mem_ready = 1'b0;
    @(negedge clk);
    chk("memwr_before_rst", {state, act_out}, {4'd5, O_MWR});
    #2 rst_n = 1'b0;
    #1 chk("async_rst_memwr", {state, act_out}, {4'd0, O_F0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_hold", {state, act_out}, {4'd0, O_F0});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
